// File: rtl/fetch_decode_ctrl_pkg.sv
// Shared definitions for the fetch/decode controller, the ALU and the bench.
package fetch_decode_ctrl_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned ADDR_W   = NIBBLE_W + BYTE_W;
  localparam int unsigned ALU_OP_W = 3;

  // Opcode map (MSB is bit 0 of the nibble)
  localparam logic [0:NIBBLE_W-1] OP_NOP       = 4'h0;
  localparam logic [0:NIBBLE_W-1] OP_ALU_FIRST = 4'h1;
  localparam logic [0:NIBBLE_W-1] OP_ALU_LAST  = 4'h7;
  localparam logic [0:NIBBLE_W-1] OP_JMP       = 4'h8;
  localparam logic [0:NIBBLE_W-1] OP_JC        = 4'h9;
  localparam logic [0:NIBBLE_W-1] OP_JZ        = 4'hA;
  localparam logic [0:NIBBLE_W-1] OP_OUT       = 4'hB;
  localparam logic [0:NIBBLE_W-1] OP_HALT      = 4'hF;

  // ALU function select: the low three opcode bits of the ALU class
  localparam logic [0:ALU_OP_W-1] ALU_IDLE = 3'b000;
  localparam logic [0:ALU_OP_W-1] ALU_F1   = 3'b001;
  localparam logic [0:ALU_OP_W-1] ALU_F2   = 3'b010;
  localparam logic [0:ALU_OP_W-1] ALU_F3   = 3'b011;
  localparam logic [0:ALU_OP_W-1] ALU_F4   = 3'b100;
  localparam logic [0:ALU_OP_W-1] ALU_F5   = 3'b101;
  localparam logic [0:ALU_OP_W-1] ALU_F6   = 3'b110;
  localparam logic [0:ALU_OP_W-1] ALU_F7   = 3'b111;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_JADDR = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_JUMP = 3'd2,
    CLS_OUT  = 3'd3,
    CLS_HALT = 3'd4
  } instr_cls_t;

  typedef enum logic [1:0] {
    JK_NONE   = 2'd0,
    JK_ALWAYS = 2'd1,
    JK_CARRY  = 2'd2,
    JK_ZERO   = 2'd3
  } jump_kind_t;

  // Branch decision from the jump kind and the flags seen in EXEC
  function automatic logic branch_taken(jump_kind_t kind, logic carry, logic zero);
    logic t;
    t = 1'b0;
    case (kind)
      JK_ALWAYS: t = 1'b1;
      JK_CARRY:  t = carry;
      JK_ZERO:   t = zero;
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fetch_decode_ctrl_instr_decode.sv
// Combinational opcode decoder: opcode nibble -> class, ALU select, jump kind.
module instr_decode
  import fetch_decode_ctrl_pkg::*;
(
  input  logic [0:NIBBLE_W-1] instr,
  output instr_cls_t          cls_c,
  output logic [0:ALU_OP_W-1] alu_op_c,
  output jump_kind_t          jump_kind_c
);

  // Classify the opcode; unlisted codes fall through as NOP
  always_comb begin
    cls_c       = CLS_NOP;
    alu_op_c    = ALU_IDLE;
    jump_kind_c = JK_NONE;
    case (instr)
      OP_JMP: begin
        cls_c       = CLS_JUMP;
        jump_kind_c = JK_ALWAYS;
      end
      OP_JC: begin
        cls_c       = CLS_JUMP;
        jump_kind_c = JK_CARRY;
      end
      OP_JZ: begin
        cls_c       = CLS_JUMP;
        jump_kind_c = JK_ZERO;
      end
      OP_OUT:  cls_c = CLS_OUT;
      OP_HALT: cls_c = CLS_HALT;
      default: begin
        if ((instr >= OP_ALU_FIRST) && (instr <= OP_ALU_LAST)) begin
          cls_c    = CLS_ALU;
          alu_op_c = instr[1:3];
        end
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch/execute sequencer: 2 cycles per plain instruction, 3 per jump.
// Every output is registered on the edge that ends the state's cycle.
module fetch_decode_ctrl
  import fetch_decode_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [0:NIBBLE_W-1] instr,
  input  logic [0:NIBBLE_W-1] oprnd,
  input  logic [0:BYTE_W-1]   prog_byte,
  input  logic                carry_in,
  input  logic                zero_in,
  output logic                pc_en,
  output logic                fetch_en,
  output logic                load,
  output logic [0:ADDR_W-1]   loadbits,
  output logic                acc_we,
  output logic [0:ALU_OP_W-1] alu_op,
  output logic                out_we,
  output logic                halted
);

  state_t              state;
  state_t              state_nxt;
  logic                take;
  logic                take_nxt;
  logic                pc_en_nxt;
  logic                fetch_en_nxt;
  logic                load_nxt;
  logic [0:ADDR_W-1]   loadbits_nxt;
  logic                acc_we_nxt;
  logic [0:ALU_OP_W-1] alu_op_nxt;
  logic                out_we_nxt;
  logic                halted_nxt;

  instr_cls_t          dec_cls_c;
  logic [0:ALU_OP_W-1] dec_alu_op_c;
  jump_kind_t          dec_jump_kind_c;

  instr_decode u_instr_decode (
    .instr       (instr),
    .cls_c       (dec_cls_c),
    .alu_op_c    (dec_alu_op_c),
    .jump_kind_c (dec_jump_kind_c)
  );

  // State, branch decision and output registers; reset clears everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_FETCH;
      take     <= 1'b0;
      pc_en    <= 1'b0;
      fetch_en <= 1'b0;
      load     <= 1'b0;
      loadbits <= '0;
      acc_we   <= 1'b0;
      alu_op   <= ALU_IDLE;
      out_we   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      take     <= take_nxt;
      pc_en    <= pc_en_nxt;
      fetch_en <= fetch_en_nxt;
      load     <= load_nxt;
      loadbits <= loadbits_nxt;
      acc_we   <= acc_we_nxt;
      alu_op   <= alu_op_nxt;
      out_we   <= out_we_nxt;
      halted   <= halted_nxt;
    end
  end

  // Next state and next output values; strobes default low, loadbits/take hold
  always_comb begin
    state_nxt    = state;
    take_nxt     = take;
    pc_en_nxt    = 1'b0;
    fetch_en_nxt = 1'b0;
    load_nxt     = 1'b0;
    loadbits_nxt = loadbits;
    acc_we_nxt   = 1'b0;
    alu_op_nxt   = ALU_IDLE;
    out_we_nxt   = 1'b0;
    halted_nxt   = 1'b0;
    case (state)
      ST_FETCH: begin
        if (run) begin
          pc_en_nxt    = 1'b1;
          fetch_en_nxt = 1'b1;
          state_nxt    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_nxt = ST_FETCH;
        case (dec_cls_c)
          CLS_ALU: begin
            acc_we_nxt = 1'b1;
            alu_op_nxt = dec_alu_op_c;
          end
          CLS_OUT: out_we_nxt = 1'b1;
          CLS_JUMP: begin
            // Target high nibble from the opcode byte, low byte from ROM at PC
            loadbits_nxt = {oprnd, prog_byte};
            take_nxt     = branch_taken(dec_jump_kind_c, carry_in, zero_in);
            state_nxt    = ST_JADDR;
          end
          CLS_HALT: begin
            halted_nxt = 1'b1;
            state_nxt  = ST_HALT;
          end
          default: state_nxt = ST_FETCH;
        endcase
      end
      ST_JADDR: begin
        // Either load the target or step over the address byte, never both
        load_nxt  = take;
        pc_en_nxt = ~take;
        state_nxt = ST_FETCH;
      end
      ST_HALT: begin
        halted_nxt = 1'b1;
        state_nxt  = ST_HALT;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: directed vector table, reset/HALT sequences,
// and a random instruction stream checked against an instruction-level model.
module tb_fetch_decode_ctrl;
  import fetch_decode_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [0:3]  instr;
  logic [0:3]  oprnd;
  logic [0:7]  prog_byte;
  logic        carry_in;
  logic        zero_in;
  logic        pc_en;
  logic        fetch_en;
  logic        load;
  logic [0:11] loadbits;
  logic        acc_we;
  logic [0:2]  alu_op;
  logic        out_we;
  logic        halted;

  fetch_decode_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .instr     (instr),
    .oprnd     (oprnd),
    .prog_byte (prog_byte),
    .carry_in  (carry_in),
    .zero_in   (zero_in),
    .pc_en     (pc_en),
    .fetch_en  (fetch_en),
    .load      (load),
    .loadbits  (loadbits),
    .acc_we    (acc_we),
    .alu_op    (alu_op),
    .out_we    (out_we),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        pe;
    logic        fe;
    logic        ld;
    logic [11:0] lb;
    logic        aw;
    logic [2:0]  op;
    logic        ow;
    logic        h;
  } exp_t;

  typedef struct {
    logic       run;
    logic [3:0] instr;
    logic [3:0] oprnd;
    logic [7:0] prog;
    logic       carry;
    logic       zero;
    exp_t       e;
  } vec_t;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  int unsigned mon_fetch = 0;
  int unsigned mon_viol  = 0;
  logic        mon_en    = 1'b0;

  function automatic exp_t mk(logic pe, logic fe, logic ld, logic [11:0] lb,
                              logic aw, logic [2:0] op, logic ow, logic h);
    exp_t e;
    e.pe = pe; e.fe = fe; e.ld = ld; e.lb = lb;
    e.aw = aw; e.op = op; e.ow = ow; e.h = h;
    return e;
  endfunction

  function automatic string fmt(exp_t e);
    return $sformatf("pe=%0b fe=%0b ld=%0b lb=%03h aw=%0b op=%0d ow=%0b h=%0b",
                     e.pe, e.fe, e.ld, e.lb, e.aw, e.op, e.ow, e.h);
  endfunction

  task automatic chk(string nm, exp_t e);
    exp_t a;
    a.pe = pc_en; a.fe = fetch_en; a.ld = load; a.lb = loadbits;
    a.aw = acc_we; a.op = alu_op; a.ow = out_we; a.h = halted;
    n_total++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got {%s} want {%s}", nm, fmt(a), fmt(e));
    end
  endtask

  task automatic chk_int(string nm, int unsigned got, int unsigned want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch-enable pulses and load/pc_en overlap seen during the random stream
  always @(negedge clk) begin
    if (mon_en) begin
      if (fetch_en)       mon_fetch <= mon_fetch + 1;
      if (load && pc_en)  mon_viol  <= mon_viol + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[16];
    exp_t       idle0;
    logic [11:0] lb_m;
    logic [3:0] op;
    logic [3:0] opr;
    logic [7:0] pb;
    logic       cin;
    logic       zin;
    logic       tk;
    logic       is_jump;
    logic       is_alu;
    int unsigned idle;

    //           run instr oprnd prog  c     z     expected outputs
    vt[0]  = '{1'b1, 4'h2, 4'h5, 8'h00, 1'b0, 1'b0, mk(1,1,0,12'h000,0,3'b000,0,0)};
    vt[1]  = '{1'b1, 4'h2, 4'h5, 8'h00, 1'b0, 1'b0, mk(0,0,0,12'h000,1,3'b010,0,0)};
    vt[2]  = '{1'b1, 4'h8, 4'hA, 8'h3C, 1'b0, 1'b0, mk(1,1,0,12'h000,0,3'b000,0,0)};
    vt[3]  = '{1'b1, 4'h8, 4'hA, 8'h3C, 1'b0, 1'b0, mk(0,0,0,12'hA3C,0,3'b000,0,0)};
    vt[4]  = '{1'b1, 4'h8, 4'hA, 8'h3C, 1'b0, 1'b0, mk(0,0,1,12'hA3C,0,3'b000,0,0)};
    vt[5]  = '{1'b1, 4'h9, 4'h1, 8'h11, 1'b0, 1'b1, mk(1,1,0,12'hA3C,0,3'b000,0,0)};
    vt[6]  = '{1'b1, 4'h9, 4'h1, 8'h11, 1'b0, 1'b1, mk(0,0,0,12'h111,0,3'b000,0,0)};
    vt[7]  = '{1'b1, 4'h9, 4'h1, 8'h11, 1'b1, 1'b1, mk(1,0,0,12'h111,0,3'b000,0,0)};
    vt[8]  = '{1'b1, 4'hA, 4'h0, 8'h40, 1'b0, 1'b1, mk(1,1,0,12'h111,0,3'b000,0,0)};
    vt[9]  = '{1'b1, 4'hA, 4'h0, 8'h40, 1'b0, 1'b1, mk(0,0,0,12'h040,0,3'b000,0,0)};
    vt[10] = '{1'b1, 4'hA, 4'h0, 8'h40, 1'b0, 1'b0, mk(0,0,1,12'h040,0,3'b000,0,0)};
    vt[11] = '{1'b0, 4'hB, 4'h0, 8'h00, 1'b0, 1'b0, mk(0,0,0,12'h040,0,3'b000,0,0)};
    vt[12] = '{1'b1, 4'hB, 4'h0, 8'h00, 1'b0, 1'b0, mk(1,1,0,12'h040,0,3'b000,0,0)};
    vt[13] = '{1'b0, 4'hB, 4'h0, 8'h00, 1'b0, 1'b0, mk(0,0,0,12'h040,0,3'b000,1,0)};
    vt[14] = '{1'b1, 4'h7, 4'h0, 8'h00, 1'b0, 1'b0, mk(1,1,0,12'h040,0,3'b000,0,0)};
    vt[15] = '{1'b1, 4'h7, 4'h0, 8'h00, 1'b0, 1'b0, mk(0,0,0,12'h040,1,3'b111,0,0)};

    idle0 = mk(0,0,0,12'h000,0,3'b000,0,0);

    // Reset takes effect without a clock edge
    reset = 1'b1; run = 1'b1; instr = 4'h0; oprnd = 4'h0; prog_byte = 8'h00;
    carry_in = 1'b0; zero_in = 1'b0;
    #2;
    chk("reset_state", idle0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: ALU, JMP, JC not taken, JZ taken, stall, OUT, ALU
    for (int i = 0; i < 16; i++) begin
      run = vt[i].run; instr = vt[i].instr; oprnd = vt[i].oprnd;
      prog_byte = vt[i].prog; carry_in = vt[i].carry; zero_in = vt[i].zero;
      tick();
      chk($sformatf("vec%0d", i), vt[i].e);
    end

    // HALT: sticky, run ignored, cleared only by reset
    run = 1'b1; instr = 4'hF;
    tick(); chk("halt_fetch", mk(1,1,0,12'h040,0,3'b000,0,0));
    tick(); chk("halt_enter", mk(0,0,0,12'h040,0,3'b000,0,1));
    for (int i = 0; i < 20; i++) begin
      instr = 4'($urandom_range(0, 15));
      tick(); chk($sformatf("halt_hold%0d", i), mk(0,0,0,12'h040,0,3'b000,0,1));
    end
    reset = 1'b1;
    #1;
    chk("halt_reset", idle0);
    @(negedge clk);
    reset = 1'b0; run = 1'b1; instr = 4'h0;
    tick(); chk("post_halt_fetch", mk(1,1,0,12'h000,0,3'b000,0,0));
    tick(); chk("post_halt_nop", idle0);

    // Reset inside JADDR of a taken JMP: no load ever issued
    instr = 4'h8; oprnd = 4'h5; prog_byte = 8'h77;
    tick(); chk("jrst_fetch", mk(1,1,0,12'h000,0,3'b000,0,0));
    tick(); chk("jrst_exec", mk(0,0,0,12'h577,0,3'b000,0,0));
    reset = 1'b1;
    #1;
    chk("jrst_async", idle0);
    tick(); chk("jrst_held", idle0);
    @(negedge clk);
    reset = 1'b0; run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("jrst_norun%0d", i), idle0);
    end
    run = 1'b1;
    tick(); chk("jrst_first_fetch", mk(1,1,0,12'h000,0,3'b000,0,0));
    instr = 4'h0;
    tick(); chk("jrst_nop", idle0);

    // Random stream: each instruction expands to its expected cycle sequence
    lb_m = 12'h000;
    mon_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      idle = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      for (int k = 0; k < int'(idle); k++) begin
        run = 1'b0; instr = 4'($urandom_range(0, 15));
        tick(); chk("r_idle", mk(0,0,0,lb_m,0,3'b000,0,0));
      end
      op  = 4'($urandom_range(0, 14));
      opr = 4'($urandom_range(0, 15));
      pb  = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      zin = 1'($urandom_range(0, 1));
      run = 1'b1; instr = op; oprnd = opr; prog_byte = pb;
      carry_in = cin; zero_in = zin;
      tick(); chk("r_fetch", mk(1,1,0,lb_m,0,3'b000,0,0));

      run     = 1'($urandom_range(0, 1));
      is_jump = (op == 4'h8) || (op == 4'h9) || (op == 4'hA);
      is_alu  = (op >= 4'h1) && (op <= 4'h7);
      tk      = (op == 4'h8) ? 1'b1 : (op == 4'h9) ? cin : zin;
      if (is_jump) lb_m = {opr, pb};
      tick();
      chk($sformatf("r_exec_op%0h", op),
          mk(0,0,0,lb_m,is_alu,is_alu ? 3'(op) : 3'b000,op == 4'hB,0));

      if (is_jump) begin
        run = 1'($urandom_range(0, 1));
        carry_in = 1'($urandom_range(0, 1));
        zero_in  = 1'($urandom_range(0, 1));
        oprnd = 4'($urandom_range(0, 15));
        prog_byte = 8'($urandom_range(0, 255));
        tick();
        chk($sformatf("r_jaddr_op%0h", op), mk(~tk,0,tk,lb_m,0,3'b000,0,0));
      end
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    chk_int("rand_fetch_count", mon_fetch, 1000);
    chk_int("rand_load_pc_en_overlap", mon_viol, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode_ctrl.md
FETCH_DECODE_CTRL -- requirements
Module: fetch_decode_ctrl

Interface
REQ-001 SHALL use clk (1-bit input) as its clock; reset is reset, asynchronous, active-high, clock clk.
REQ-002 SHALL have these ports; all vectors indexed [0:N-1], bit 0 = MSB:
  clk        in   1   clock
  reset      in   1   async active-high reset
  run        in   1   1 = allow new fetches
  instr      in   4   registered opcode nibble from fetch register
  oprnd      in   4   registered operand nibble from fetch register
  prog_byte  in   8   current ROM output (byte at PC)
  carry_in   in   1   ALU carry flag
  zero_in    in   1   ALU zero flag
  pc_en      out  1   PC increment enable
  fetch_en   out  1   fetch register load enable
  load       out  1   PC parallel-load strobe
  loadbits   out  12  PC load value
  acc_we     out  1   accumulator write strobe
  alu_op     out  3   ALU function select
  out_we     out  1   output-port write strobe
  halted     out  1   1 = in HALT state

Function
REQ-003 SHALL implement states FETCH, EXEC, JADDR, HALT; all outputs registered.
REQ-004 FETCH: run=1 -> pc_en=1, fetch_en=1 for exactly that cycle, next EXEC; run=0 -> all strobes 0, stay FETCH.
REQ-005 EXEC: decode instr (valid this cycle); PC already points to byte following the opcode.
REQ-006 Opcode map: 0x0 NOP; 0x1-0x7 ALU class -> acc_we=1, alu_op=instr[1:3]; 0x8 JMP; 0x9 JC; 0xA JZ; 0xB OUT -> out_we=1; 0xC-0xE NOP; 0xF HALT.
REQ-007 Non-jump, non-HALT opcodes: strobes asserted for the single EXEC cycle, next FETCH; 2 cycles/instruction.
REQ-008 JMP/JC/JZ: at end of EXEC capture loadbits={oprnd, prog_byte} and take bit (JMP=1, JC=carry_in, JZ=zero_in sampled in EXEC), next JADDR.
REQ-009 JADDR: take=1 -> load=1, pc_en=0; take=0 -> pc_en=1 (skip address byte), load=0; next FETCH; 3 cycles/jump.
REQ-010 load and pc_en SHALL never be 1 in the same cycle; fetch_en SHALL be 1 only in FETCH.
REQ-011 HALT opcode: next HALT; halted=1, all strobes 0; exit only by reset; run ignored.
REQ-012 run deasserted during EXEC/JADDR SHALL NOT abort the instruction; it only blocks the next FETCH.
REQ-013 loadbits SHALL hold its last captured value outside JADDR.
REQ-014 Flags sampled only in EXEC; flag changes in JADDR have no effect.

Reset
REQ-015 reset=1 SHALL immediately force state FETCH, pc_en=fetch_en=load=acc_we=out_we=halted=0, alu_op=0, loadbits=0, take=0.
REQ-016 reset mid-instruction (EXEC/JADDR) SHALL abort with no load or write strobe issued; first fetch on first clk edge after reset release with run=1.

Structure
REQ-017 Opcode constants, alu_op encodings and state encoding SHALL reside in a shared package, also used by the ALU and bench.
REQ-018 Opcode decode SHALL be one combinational sub-module, instr_decode (instr -> class, alu_op, jump kind).
REQ-019 Target size 120-400 RTL lines; no memories inside the block.

Verification
REQ-020 reset, run=1, instr=0x2 oprnd=0x5 -> cycle1 pc_en=fetch_en=1; cycle2 acc_we=1, alu_op=3'b010; cycle3 FETCH again.
REQ-021 instr=0x8 oprnd=0xA, prog_byte=0x3C in EXEC -> JADDR: load=1, loadbits=0xA3C, pc_en=0.
REQ-022 instr=0x9, carry_in=0, prog_byte=0x11 -> JADDR: load=0, pc_en=1; instr=0xA, zero_in=1, oprnd=0x0, prog_byte=0x40 -> load=1, loadbits=0x040.
REQ-023 instr=0xF -> halted=1 from next cycle, no strobes for 20 cycles with run=1; reset -> halted=0, FETCH.
REQ-024 assert reset during JADDR of taken JMP -> load stays 0, outputs 0 same cycle; run=0 after reset -> no fetch_en until run=1.
REQ-025 random opcode stream 1000 instructions -> never load&pc_en together, fetch_en only in FETCH, cycle count matches 2/3 per instruction.
